// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared types and constants for the data-memory responder that sits between
// the L1 D-cache miss/write-through port and the single-port data SRAM macro.
//
// Contents:
//   dm_state_e           responder FSM states (IDLE -> WAIT -> ACCESS -> RESP)
//   DM_LAT_W             width of the latency down-counter (latency 1..15)
//   DM_CNT_W             width of the completed-read/-write counters
//   DM_DEFAULT_*         default values for the responder parameters
// ---------------------------------------------------------------------------
package dm_pkg;

  // Responder request life cycle. One request is in flight at a time.
  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_ACCESS,
    DM_RESP
  } dm_state_e;

  localparam int DM_LAT_W           = 4;
  localparam int DM_CNT_W           = 64;
  localparam int DM_DEFAULT_DATA_W  = 32;
  localparam int DM_DEFAULT_MEM_AW  = 14;
  localparam int DM_DEFAULT_LATENCY = 4;

endpackage

// File: rtl/dm_wait_counter.sv
// ---------------------------------------------------------------------------
// dm_wait_counter
// Down-counter that paces the responder between accepting a request and
// touching the SRAM. It is loaded with LATENCY-1 on acceptance, counts down
// while the responder waits, and flags expiry when it reaches one, so that the
// edge on which it expires is the edge that moves the FSM into ACCESS.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high (clears the count)
//   load_i     in   load loadVal_i this cycle (request accepted)
//   loadVal_i  in   DM_LAT_W value to load (LATENCY-1)
//   dec_i      in   decrement this cycle (responder waiting)
//   expire_o   out  count currently equals one
// ---------------------------------------------------------------------------
module dm_wait_counter
  import dm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [DM_LAT_W-1:0] loadVal_i,
  input  logic                dec_i,
  output logic                expire_o
);

  logic [DM_LAT_W-1:0] count_q;
  logic [DM_LAT_W-1:0] count_d;

  // Next count: a load wins over a decrement, and the count saturates at zero
  // so a stray decrement can never wrap it round to a large value.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == DM_LAT_W'(1));

endmodule

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
// Memory-side responder for the D-cache miss/write-through port. It accepts a
// single word request, waits LATENCY cycles, performs exactly one access on a
// single-port synchronous SRAM macro (CS/OE/WEB style) and returns a one-cycle
// ready pulse. Read data is held on DataOut between responses.
//
// Parameters:
//   DATA_W   word width
//   MEM_AW   SRAM word-address width; DM_address[MEM_AW+1:2] is used, upper
//            address bits alias and bits [1:0] are ignored
//   LATENCY  cycles from acceptance to the SRAM access, legal range 1..15
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-high; aborts any request
//   DM_enable   in   request valid, held by the initiator until ready
//   DM_write    in   1 = word write, 0 = word read
//   DM_address  in   byte address
//   DM_in       in   write data
//   DataOut     out  read data (SRAM data during a read response, otherwise
//                    the last read word)
//   ready       out  one-cycle completion pulse
//   SRAM_CS     out  macro chip select
//   SRAM_OE     out  macro output enable
//   SRAM_WEB    out  macro write enable, active-low
//   SRAM_A      out  macro word address
//   SRAM_DI     out  macro write data
//   SRAM_DO     in   macro read data, valid the cycle after a CS&OE cycle
//   DM_reads    out  completed-read counter (wraps)
//   DM_writes   out  completed-write counter (wraps)
// ---------------------------------------------------------------------------
module dm_responder
  import dm_pkg::*;
#(
  parameter int DATA_W  = DM_DEFAULT_DATA_W,
  parameter int MEM_AW  = DM_DEFAULT_MEM_AW,
  parameter int LATENCY = DM_DEFAULT_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                DM_enable,
  input  logic                DM_write,
  input  logic [DATA_W-1:0]   DM_address,
  input  logic [DATA_W-1:0]   DM_in,
  output logic [DATA_W-1:0]   DataOut,
  output logic                ready,
  output logic                SRAM_CS,
  output logic                SRAM_OE,
  output logic                SRAM_WEB,
  output logic [MEM_AW-1:0]   SRAM_A,
  output logic [DATA_W-1:0]   SRAM_DI,
  input  logic [DATA_W-1:0]   SRAM_DO,
  output logic [DM_CNT_W-1:0] DM_reads,
  output logic [DM_CNT_W-1:0] DM_writes
);

  // With a latency of one the WAIT state is skipped entirely.
  localparam logic [DM_LAT_W-1:0] LOAD_VAL   = DM_LAT_W'(LATENCY - 1);
  localparam bit                  MULTI_WAIT = (LATENCY > 1);

  dm_state_e            state_q;
  dm_state_e            state_d;
  logic [MEM_AW-1:0]    reqAddr_q;
  logic                 reqWrite_q;
  logic [DATA_W-1:0]    reqData_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DM_CNT_W-1:0]  readCount_q;
  logic [DM_CNT_W-1:0]  writeCount_q;

  logic                 accept;
  logic                 waitDec;
  logic                 waitExpire;
  logic                 unusedAddrBits;

  // Only the word-address slice reaches the macro; byte-offset bits and the
  // aliasing upper bits are deliberately dropped.
  assign unusedAddrBits = ^{DM_address[DATA_W-1:MEM_AW+2], DM_address[1:0]};

  assign accept  = (state_q == DM_IDLE) && DM_enable;
  assign waitDec = (state_q == DM_WAIT);

  // Latency pacing: loaded on acceptance, counts down through WAIT, and
  // expires on the last WAIT cycle.
  dm_wait_counter u_waitCounter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .loadVal_i (LOAD_VAL),
    .dec_i     (waitDec),
    .expire_o  (waitExpire)
  );

  // Next-state logic. ACCESS and RESP each last exactly one cycle, and RESP
  // always returns to IDLE, so a DM_enable still high after ready is treated
  // as a fresh request one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DM_IDLE: begin
        if (DM_enable) begin
          state_d = MULTI_WAIT ? DM_WAIT : DM_ACCESS;
        end
      end
      DM_WAIT: begin
        if (waitExpire) begin
          state_d = DM_ACCESS;
        end
      end
      DM_ACCESS: state_d = DM_RESP;
      DM_RESP:   state_d = DM_IDLE;
      default:   state_d = DM_IDLE;
    endcase
  end

  // Output decode. The SRAM strobes are gated by rst combinationally so a
  // reset that lands on an ACCESS cycle can never let a write reach the macro.
  // During a read response the macro output is forwarded straight to DataOut;
  // otherwise the last captured read word is presented.
  always_comb begin
    ready    = 1'b0;
    SRAM_CS  = 1'b0;
    SRAM_OE  = 1'b0;
    SRAM_WEB = 1'b1;
    SRAM_A   = '0;
    SRAM_DI  = '0;
    DataOut  = rdata_q;
    if (rst) begin
      DataOut = '0;
    end else begin
      unique case (state_q)
        DM_ACCESS: begin
          SRAM_CS = 1'b1;
          SRAM_A  = reqAddr_q;
          if (reqWrite_q) begin
            SRAM_WEB = 1'b0;
            SRAM_DI  = reqData_q;
          end else begin
            SRAM_OE = 1'b1;
          end
        end
        DM_RESP: begin
          ready = 1'b1;
          if (!reqWrite_q) begin
            DataOut = SRAM_DO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State register, request capture, read-data hold and completion counters.
  // Request inputs are sampled only on the accepting edge, so anything the
  // initiator does to DM_* while a request is in flight is ignored. The
  // counters advance at the end of RESP, and since a response is either a
  // read or a write they can never both step in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DM_IDLE;
      reqAddr_q    <= '0;
      reqWrite_q   <= 1'b0;
      reqData_q    <= '0;
      rdata_q      <= '0;
      readCount_q  <= '0;
      writeCount_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        reqAddr_q  <= DM_address[MEM_AW+1:2];
        reqWrite_q <= DM_write;
        reqData_q  <= DM_in;
      end
      if (state_q == DM_RESP) begin
        if (reqWrite_q) begin
          writeCount_q <= writeCount_q + 1'b1;
        end else begin
          readCount_q <= readCount_q + 1'b1;
          rdata_q     <= SRAM_DO;
        end
      end
    end
  end

  assign DM_reads  = readCount_q;
  assign DM_writes = writeCount_q;

endmodule

// File: tb/tb_dm_responder.sv
// ---------------------------------------------------------------------------
// tb_dm_responder
// Scoreboard bench for dm_responder. Two instances share the clock and reset:
// dut0 with LATENCY=4 and dut1 with LATENCY=1. Each has a behavioural SRAM
// macro. The driver pushes the expected response and expected SRAM access for
// every request; a monitor pops and compares whenever an instance raises ready
// or drives SRAM_CS.
// ---------------------------------------------------------------------------
module tb_dm_responder;

  typedef struct {
    int          idx;
    bit          isWrite;
    logic [31:0] data;
    longint      cycle;
  } rspExp_t;

  typedef struct {
    int          idx;
    bit          isWrite;
    logic [13:0] addr;
    logic [31:0] data;
    longint      cycle;
  } sramExp_t;

  logic        clk;
  logic        rst;
  logic        enV     [2];
  logic        wrV     [2];
  logic [31:0] addrV   [2];
  logic [31:0] dinV    [2];
  logic [31:0] doutV   [2];
  logic        readyV  [2];
  logic        csV     [2];
  logic        oeV     [2];
  logic        webV    [2];
  logic [13:0] aV      [2];
  logic [31:0] diV     [2];
  logic [31:0] doV     [2];
  logic [63:0] readsV  [2];
  logic [63:0] writesV [2];

  logic [31:0] mem [2][16384];
  logic [31:0] lastRead [2];

  rspExp_t  rspQ[$];
  sramExp_t sramQ[$];
  rspExp_t  rCur;
  sramExp_t sCur;

  longint cycleCount = 0;
  int     checks = 0;
  int     errors = 0;

  dm_responder #(.DATA_W(32), .MEM_AW(14), .LATENCY(4)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .DM_enable  (enV[0]),
    .DM_write   (wrV[0]),
    .DM_address (addrV[0]),
    .DM_in      (dinV[0]),
    .DataOut    (doutV[0]),
    .ready      (readyV[0]),
    .SRAM_CS    (csV[0]),
    .SRAM_OE    (oeV[0]),
    .SRAM_WEB   (webV[0]),
    .SRAM_A     (aV[0]),
    .SRAM_DI    (diV[0]),
    .SRAM_DO    (doV[0]),
    .DM_reads   (readsV[0]),
    .DM_writes  (writesV[0])
  );

  dm_responder #(.DATA_W(32), .MEM_AW(14), .LATENCY(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .DM_enable  (enV[1]),
    .DM_write   (wrV[1]),
    .DM_address (addrV[1]),
    .DM_in      (dinV[1]),
    .DataOut    (doutV[1]),
    .ready      (readyV[1]),
    .SRAM_CS    (csV[1]),
    .SRAM_OE    (oeV[1]),
    .SRAM_WEB   (webV[1]),
    .SRAM_A     (aV[1]),
    .SRAM_DI    (diV[1]),
    .SRAM_DO    (doV[1]),
    .DM_reads   (readsV[1]),
    .DM_writes  (writesV[1])
  );

  // Free-running clock and an edge counter used to time every expectation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural synchronous SRAM macros: write on CS&!WEB, registered read
  // data one cycle after CS&OE.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (csV[i] && !webV[i]) mem[i][aV[i]] <= diV[i];
      if (csV[i] && oeV[i])   doV[i] <= mem[i][aV[i]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d",
               name, actual, expected, cycleCount);
    end
  endtask

  // Monitor: compares every ready pulse and every SRAM access against the
  // front of the matching expectation queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (readyV[i]) begin
        if (rspQ.size() == 0 || rspQ[0].idx != i) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedReady dut%0d actual=1 required=0 at cycle %0d",
                   i, cycleCount);
        end else begin
          rCur = rspQ.pop_front();
          checkOutput($sformatf("dut%0d readyCycle", i), 64'(cycleCount), 64'(rCur.cycle));
          checkOutput($sformatf("dut%0d DataOut", i), 64'(doutV[i]), 64'(rCur.data));
        end
      end
      if (csV[i]) begin
        if (sramQ.size() == 0 || sramQ[0].idx != i) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedSramAccess dut%0d actual=CS1 required=CS0 at cycle %0d",
                   i, cycleCount);
        end else begin
          sCur = sramQ.pop_front();
          checkOutput($sformatf("dut%0d sramCycle", i), 64'(cycleCount), 64'(sCur.cycle));
          checkOutput($sformatf("dut%0d SRAM_WEB", i), 64'(webV[i]), 64'(!sCur.isWrite));
          checkOutput($sformatf("dut%0d SRAM_OE", i), 64'(oeV[i]), 64'(!sCur.isWrite));
          checkOutput($sformatf("dut%0d SRAM_A", i), 64'(aV[i]), 64'(sCur.addr));
          if (sCur.isWrite)
            checkOutput($sformatf("dut%0d SRAM_DI", i), 64'(diV[i]), 64'(sCur.data));
        end
      end
    end
  end

  // Issue one request, record its expected SRAM access and response, then
  // wait (bounded) for ready. DM_enable is left high on return.
  task automatic applyStimulus(input int idx, input bit isWrite,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] expRead, input bit scramble);
    rspExp_t  r;
    sramExp_t s;
    longint   lat;
    bit       got;
    lat = (idx == 0) ? 64'd4 : 64'd1;
    @(negedge clk);
    enV[idx]   = 1'b1;
    wrV[idx]   = isWrite;
    addrV[idx] = addr;
    dinV[idx]  = data;
    r.idx      = idx;
    r.isWrite  = isWrite;
    r.data     = isWrite ? lastRead[idx] : expRead;
    r.cycle    = cycleCount + 1 + lat;
    rspQ.push_back(r);
    if (!isWrite) lastRead[idx] = expRead;
    s.idx      = idx;
    s.isWrite  = isWrite;
    s.addr     = addr[15:2];
    s.data     = data;
    s.cycle    = cycleCount + lat;
    sramQ.push_back(s);
    if (scramble) begin
      @(negedge clk);
      addrV[idx] = addr ^ 32'h0000_0100;
      dinV[idx]  = ~data;
      wrV[idx]   = ~isWrite;
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (readyV[idx]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout dut%0d actual=noReady required=ready", idx);
    end
  endtask

  task automatic dropEnable(input int idx);
    enV[idx] = 1'b0;
  endtask

  // Watchdog so the run always ends even if the design locks up.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enV[i] = 1'b0; wrV[i] = 1'b0; addrV[i] = '0; dinV[i] = '0;
      lastRead[i] = '0;
    end

    // Reset held for two cycles: every output at its reset value.
    repeat (2) @(negedge clk);
    checkOutput("rst ready", 64'(readyV[0]), 64'd0);
    checkOutput("rst SRAM_CS", 64'(csV[0]), 64'd0);
    checkOutput("rst SRAM_OE", 64'(oeV[0]), 64'd0);
    checkOutput("rst SRAM_WEB", 64'(webV[0]), 64'd1);
    checkOutput("rst SRAM_A", 64'(aV[0]), 64'd0);
    checkOutput("rst SRAM_DI", 64'(diV[0]), 64'd0);
    checkOutput("rst DataOut", 64'(doutV[0]), 64'd0);
    checkOutput("rst DM_reads", readsV[0], 64'd0);
    checkOutput("rst DM_writes", writesV[0], 64'd0);
    checkOutput("rst dut1 SRAM_WEB", 64'(webV[1]), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle SRAM_WEB", 64'(webV[0]), 64'd1);

    // Single write, then more writes to preload addresses used later.
    applyStimulus(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0);
    dropEnable(0);
    @(negedge clk);
    checkOutput("write1 DM_writes", writesV[0], 64'd1);
    checkOutput("write1 DM_reads", readsV[0], 64'd0);
    applyStimulus(0, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h0000_0300, 32'h7777_7777, 32'h0, 1'b0);
    dropEnable(0);

    // Read back, with DataOut held afterwards; then an aliased, misaligned
    // address that maps to the same word.
    applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0);
    dropEnable(0);
    @(negedge clk);
    checkOutput("read1 DataOut held", 64'(doutV[0]), 64'hDEAD_BEEF);
    checkOutput("read1 DM_reads", readsV[0], 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("read1 DataOut still held", 64'(doutV[0]), 64'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 32'h0001_0043, 32'h0, 32'hDEAD_BEEF, 1'b0);
    dropEnable(0);

    // Four-word fill then four-word refill with DM_enable held throughout.
    for (int w = 0; w < 4; w++)
      applyStimulus(0, 1'b1, 32'h0000_0100 + 32'(4 * w), 32'hA000_0000 + 32'(w), 32'h0, 1'b0);
    dropEnable(0);
    for (int w = 0; w < 4; w++)
      applyStimulus(0, 1'b0, 32'h0000_0100 + 32'(4 * w), 32'h0, 32'hA000_0000 + 32'(w), 1'b0);
    dropEnable(0);
    @(negedge clk);
    checkOutput("refill DM_reads", readsV[0], 64'd6);
    checkOutput("refill DM_writes", writesV[0], 64'd7);

    // Inputs changed during WAIT must not affect the access.
    applyStimulus(0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1'b1);
    dropEnable(0);
    applyStimulus(0, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0300, 32'h0, 32'h7777_7777, 1'b0);
    dropEnable(0);
    @(negedge clk);
    checkOutput("scramble DM_reads", readsV[0], 64'd8);
    checkOutput("scramble DM_writes", writesV[0], 64'd8);

    // Reset arriving in the ACCESS cycle of a write aborts it.
    @(negedge clk);
    enV[0] = 1'b1; wrV[0] = 1'b1; addrV[0] = 32'h0000_0080; dinV[0] = 32'h55AA_55AA;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    enV[0] = 1'b0;
    @(negedge clk);
    checkOutput("abort SRAM_WEB", 64'(webV[0]), 64'd1);
    checkOutput("abort SRAM_CS", 64'(csV[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort ready", 64'(readyV[0]), 64'd0);
    checkOutput("abort DM_writes", writesV[0], 64'd0);
    checkOutput("abort DM_reads", readsV[0], 64'd0);
    checkOutput("abort DataOut", 64'(doutV[0]), 64'd0);
    lastRead[0] = '0;
    lastRead[1] = '0;
    applyStimulus(0, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 1'b0);
    dropEnable(0);
    @(negedge clk);
    checkOutput("postAbort DM_reads", readsV[0], 64'd1);

    // LATENCY=1 instance: ready two edges after acceptance.
    applyStimulus(1, 1'b1, 32'h0000_0044, 32'h1234_5678, 32'h0, 1'b0);
    dropEnable(1);
    applyStimulus(1, 1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1'b0);
    dropEnable(1);
    @(negedge clk);
    checkOutput("fast DM_reads", readsV[1], 64'd1);
    checkOutput("fast DM_writes", writesV[1], 64'd1);
    checkOutput("fast DataOut held", 64'(doutV[1]), 64'h1234_5678);

    repeat (3) @(negedge clk);
    checkOutput("rspQ drained", 64'(rspQ.size()), 64'd0);
    checkOutput("sramQ drained", 64'(sramQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
